// File: rtl/kinematic_ramp_controller.sv
// Body-velocity (vx, vy, wz) to four mecanum wheel-speed targets via one shared multiplier.
// Optional slew limiter on the wheel outputs is enabled with KINEMATIC_RAMP_CONTROLLER_RAMP_EN.
module kinematic_ramp_controller #(
  parameter int N_WIDTH   = 17,
  parameter int Q_WIDTH   = 8,
  parameter int K_GEOM    = 64,
  parameter int INV_R     = 1280,
  parameter int RAMP_STEP = 16,
  parameter int RAMP_DIV  = 50000
) (
  input  logic                      KINEMATIC_RAMP_CONTROLLER_CLOCK_50,
  input  logic                      KINEMATIC_RAMP_CONTROLLER_RESET_InHigh,
  input  logic signed [N_WIDTH-1:0] KINEMATIC_RAMP_CONTROLLER_TARGETVX_InBus,
  input  logic signed [N_WIDTH-1:0] KINEMATIC_RAMP_CONTROLLER_TARGETVY_InBus,
  input  logic signed [N_WIDTH-1:0] KINEMATIC_RAMP_CONTROLLER_TARGETWZ_InBus,
  input  logic                      KINEMATIC_RAMP_CONTROLLER_TARGETVALID_In,
  output logic signed [N_WIDTH-1:0] KINEMATIC_RAMP_CONTROLLER_W1_OutBus,
  output logic signed [N_WIDTH-1:0] KINEMATIC_RAMP_CONTROLLER_W2_OutBus,
  output logic signed [N_WIDTH-1:0] KINEMATIC_RAMP_CONTROLLER_W3_OutBus,
  output logic signed [N_WIDTH-1:0] KINEMATIC_RAMP_CONTROLLER_W4_OutBus,
  output logic                      KINEMATIC_RAMP_CONTROLLER_BUSY_Out,
  output logic                      KINEMATIC_RAMP_CONTROLLER_CMDDONE_Out,
  output logic                      KINEMATIC_RAMP_CONTROLLER_ATTARGET_Out
);
  localparam int P_WIDTH = 2 * N_WIDTH;
  localparam int S_WIDTH = N_WIDTH + 2;
  localparam logic signed [P_WIDTH-1:0] MAX_WIDE = P_WIDTH'((64'sd1 <<< (N_WIDTH - 1)) - 64'sd1);
  localparam logic signed [P_WIDTH-1:0] MIN_WIDE = -MAX_WIDE - 1;
  localparam logic signed [N_WIDTH-1:0] K_GEOM_S = N_WIDTH'(K_GEOM);
  localparam logic signed [N_WIDTH-1:0] INV_R_S  = N_WIDTH'(INV_R);

  typedef enum logic [1:0] {IDLE, MULK, SUM, SCALE} state_t;

  logic clk, rst, valid;
  logic signed [N_WIDTH-1:0] inVx, inVy, inWz;
  assign clk   = KINEMATIC_RAMP_CONTROLLER_CLOCK_50;
  assign rst   = KINEMATIC_RAMP_CONTROLLER_RESET_InHigh;
  assign valid = KINEMATIC_RAMP_CONTROLLER_TARGETVALID_In;
  assign inVx  = KINEMATIC_RAMP_CONTROLLER_TARGETVX_InBus;
  assign inVy  = KINEMATIC_RAMP_CONTROLLER_TARGETVY_InBus;
  assign inWz  = KINEMATIC_RAMP_CONTROLLER_TARGETWZ_InBus;

  state_t state;
  logic [1:0] scaleIdx;
  logic busy, cmdDone, pendValid, commit;
  logic signed [N_WIDTH-1:0] cmdVx, cmdVy, cmdWz, pendVx, pendVy, pendWz, kwReg;
  logic signed [N_WIDTH-1:0] sumReg [4];
  logic signed [N_WIDTH-1:0] sumNext [4];
  logic signed [N_WIDTH-1:0] scaleReg [3];
  logic signed [N_WIDTH-1:0] target [4];
  logic signed [N_WIDTH-1:0] targetNext [4];
  logic signed [N_WIDTH-1:0] wheel [4];
  logic signed [N_WIDTH-1:0] wheelNext [4];
  logic signed [N_WIDTH-1:0] mulA, mulB, mulScaled;
  logic signed [P_WIDTH-1:0] mulProd;
  logic signed [S_WIDTH-1:0] sVx, sVy, sKw;

  function automatic logic signed [N_WIDTH-1:0] satWide(input logic signed [P_WIDTH-1:0] v);
    if (v > MAX_WIDE) return N_WIDTH'(MAX_WIDE);
    if (v < MIN_WIDE) return N_WIDTH'(MIN_WIDE);
    return N_WIDTH'(v);
  endfunction

  // Shared multiplier: K_GEOM*wz during MULK, sum*INV_R for one wheel per SCALE cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    mulA = cmdWz;
    mulB = K_GEOM_S;
    if (state == SCALE) begin
      mulA = sumReg[scaleIdx];
      mulB = INV_R_S;
    end
    mulProd   = mulA * mulB;
    mulScaled = satWide(mulProd >>> Q_WIDTH);
  end

  always_comb begin
    sVx = S_WIDTH'(cmdVx);
    sVy = S_WIDTH'(cmdVy);
    sKw = S_WIDTH'(kwReg);
    sumNext[0] = satWide(P_WIDTH'(sVx - sVy - sKw));
    sumNext[1] = satWide(P_WIDTH'(sVx + sVy + sKw));
    sumNext[2] = satWide(P_WIDTH'(sVx + sVy - sKw));
    sumNext[3] = satWide(P_WIDTH'(sVx - sVy + sKw));
  end

  // All four targets change on the same edge; the last wheel comes straight off the multiplier.
  assign commit = (state == SCALE) && (scaleIdx == 2'd3);

  always_comb begin
    for (int i = 0; i < 4; i++) targetNext[i] = target[i];
    if (commit) begin
      for (int i = 0; i < 3; i++) targetNext[i] = scaleReg[i];
      targetNext[3] = mulScaled;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments only, so every read sees pre-edge values.
    if (rst) begin
      state     <= IDLE;
      scaleIdx  <= 2'd0;
      busy      <= 1'b0;
      cmdDone   <= 1'b0;
      pendValid <= 1'b0;
    end else begin
      cmdDone <= 1'b0;
      if (valid && state != IDLE) pendValid <= 1'b1;
      unique case (state)
        IDLE: if (valid || pendValid) begin
          state     <= MULK;
          busy      <= 1'b1;
          pendValid <= 1'b0;
        end
        MULK: state <= SUM;
        SUM: begin
          state    <= SCALE;
          scaleIdx <= 2'd0;
        end
        SCALE: begin
          scaleIdx <= scaleIdx + 2'd1;
          if (scaleIdx == 2'd3) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cmdDone <= 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: pipeline scratch registers carry no reset; the FSM's reset makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (valid) begin
        cmdVx <= inVx;
        cmdVy <= inVy;
        cmdWz <= inWz;
      end else if (pendValid) begin
        cmdVx <= pendVx;
        cmdVy <= pendVy;
        cmdWz <= pendWz;
      end
    end
    if (valid && state != IDLE) begin
      pendVx <= inVx;
      pendVy <= inVy;
      pendWz <= inWz;
    end
    if (state == MULK) kwReg <= mulScaled;
    if (state == SUM) for (int i = 0; i < 4; i++) sumReg[i] <= sumNext[i];
    if (state == SCALE && scaleIdx != 2'd3) scaleReg[scaleIdx] <= mulScaled;
  end

`ifdef KINEMATIC_RAMP_CONTROLLER_RAMP_EN
  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic signed [N_WIDTH:0] STEP_S = (N_WIDTH + 1)'(RAMP_STEP);

  logic [CNT_W-1:0] tickCnt;
  logic tick, atTarget, atTargetNext;
  logic signed [N_WIDTH:0] rampDiff [4];

  assign tick = (tickCnt == CNT_W'(RAMP_DIV - 1));

  // Ramp compares against the pre-commit targets, so a coincident commit applies from the next tick.
  always_comb begin
    atTargetNext = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wheelNext[i] = wheel[i];
      rampDiff[i]  = (N_WIDTH + 1)'(target[i]) - (N_WIDTH + 1)'(wheel[i]);
      if (tick) begin
        if (rampDiff[i] > STEP_S)       wheelNext[i] = wheel[i] + N_WIDTH'(RAMP_STEP);
        else if (rampDiff[i] < -STEP_S) wheelNext[i] = wheel[i] - N_WIDTH'(RAMP_STEP);
        else                            wheelNext[i] = target[i];
      end
      if (wheelNext[i] != targetNext[i]) atTargetNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tickCnt  <= '0;
      atTarget <= 1'b1;
    end else begin
      tickCnt  <= tick ? '0 : tickCnt + 1'b1;
      atTarget <= atTargetNext;
    end
  end

  assign KINEMATIC_RAMP_CONTROLLER_ATTARGET_Out = atTarget;
`else
  always_comb begin
    for (int i = 0; i < 4; i++) wheelNext[i] = commit ? targetNext[i] : wheel[i];
  end

  assign KINEMATIC_RAMP_CONTROLLER_ATTARGET_Out = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        target[i] <= '0;
        wheel[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        target[i] <= targetNext[i];
        wheel[i]  <= wheelNext[i];
      end
    end
  end

  assign KINEMATIC_RAMP_CONTROLLER_W1_OutBus   = wheel[0];
  assign KINEMATIC_RAMP_CONTROLLER_W2_OutBus   = wheel[1];
  assign KINEMATIC_RAMP_CONTROLLER_W3_OutBus   = wheel[2];
  assign KINEMATIC_RAMP_CONTROLLER_W4_OutBus   = wheel[3];
  assign KINEMATIC_RAMP_CONTROLLER_BUSY_Out    = busy;
  assign KINEMATIC_RAMP_CONTROLLER_CMDDONE_Out = cmdDone;
endmodule

// File: tb/tb_kinematic_ramp_controller.sv
// Bench for kinematic_ramp_controller: directed scenarios plus random commands against a
// cycle-level behavioural model; follows KINEMATIC_RAMP_CONTROLLER_RAMP_EN like the design.
module tb_kinematic_ramp_controller;
  localparam int N    = 17;
  localparam int Q    = 8;
  localparam int KG   = 64;
  localparam int IR   = 1280;
  localparam int STEP = 16;
  localparam int DIV  = 4;
  localparam int MAXV = (1 << (N - 1)) - 1;
  localparam int MINV = -(1 << (N - 1));
  localparam int LAT  = 6;

  typedef int quad_t [4];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic signed [N-1:0] vx = '0, vy = '0, wz = '0;
  logic signed [N-1:0] w1, w2, w3, w4;
  logic busy, cmdDone, atTarget;

  always #10 clk = ~clk;

  kinematic_ramp_controller #(
    .N_WIDTH(N), .Q_WIDTH(Q), .K_GEOM(KG), .INV_R(IR), .RAMP_STEP(STEP), .RAMP_DIV(DIV)
  ) dut (
    .KINEMATIC_RAMP_CONTROLLER_CLOCK_50      (clk),
    .KINEMATIC_RAMP_CONTROLLER_RESET_InHigh  (rst),
    .KINEMATIC_RAMP_CONTROLLER_TARGETVX_InBus(vx),
    .KINEMATIC_RAMP_CONTROLLER_TARGETVY_InBus(vy),
    .KINEMATIC_RAMP_CONTROLLER_TARGETWZ_InBus(wz),
    .KINEMATIC_RAMP_CONTROLLER_TARGETVALID_In(valid),
    .KINEMATIC_RAMP_CONTROLLER_W1_OutBus     (w1),
    .KINEMATIC_RAMP_CONTROLLER_W2_OutBus     (w2),
    .KINEMATIC_RAMP_CONTROLLER_W3_OutBus     (w3),
    .KINEMATIC_RAMP_CONTROLLER_W4_OutBus     (w4),
    .KINEMATIC_RAMP_CONTROLLER_BUSY_Out      (busy),
    .KINEMATIC_RAMP_CONTROLLER_CMDDONE_Out   (cmdDone),
    .KINEMATIC_RAMP_CONTROLLER_ATTARGET_Out  (atTarget)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkQuad(input string name, input int e1, input int e2, input int e3, input int e4);
    check({name, "_w1"}, w1, e1);
    check({name, "_w2"}, w2, e2);
    check({name, "_w3"}, w3, e3);
    check({name, "_w4"}, w4, e4);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return int'(v);
  endfunction

  function automatic quad_t ikTargets(input int x, input int y, input int z);
    quad_t t;
    int kw;
    int s [4];
    kw = sat((longint'(KG) * z) >>> Q);
    s[0] = sat(x - y - kw);
    s[1] = sat(x + y + kw);
    s[2] = sat(x + y - kw);
    s[3] = sat(x - y + kw);
    for (int i = 0; i < 4; i++) t[i] = sat((longint'(s[i]) * IR) >>> Q);
    return t;
  endfunction

  function automatic int stepToward(input int w, input int t);
    if (t - w > STEP) return w + STEP;
    if (t - w < -STEP) return w - STEP;
    return t;
  endfunction

  quad_t mTarget, mWheel, mNextTarget;
  int mRemain, mTick, pVx, pVy, pWz;
  bit mPend, mDone, mAt, modelOn = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mTarget[i] = 0;
        mWheel[i]  = 0;
      end
      mRemain = 0;
      mTick   = 0;
      mPend   = 1'b0;
      mDone   = 1'b0;
      mAt     = 1'b1;
      modelOn = 1'b1;
    end else if (modelOn) begin
      mDone = 1'b0;
`ifdef KINEMATIC_RAMP_CONTROLLER_RAMP_EN
      if (mTick == DIV - 1)
        for (int i = 0; i < 4; i++) mWheel[i] = stepToward(mWheel[i], mTarget[i]);
      mTick = (mTick + 1) % DIV;
`endif
      if (mRemain > 0) begin
        if (valid) begin
          mPend = 1'b1;
          pVx = vx;
          pVy = vy;
          pWz = wz;
        end
        mRemain--;
        if (mRemain == 0) begin
          mTarget = mNextTarget;
          mDone   = 1'b1;
`ifndef KINEMATIC_RAMP_CONTROLLER_RAMP_EN
          mWheel = mTarget;
`endif
        end
      end else if (valid || mPend) begin
        mNextTarget = valid ? ikTargets(vx, vy, wz) : ikTargets(pVx, pVy, pWz);
        mPend   = 1'b0;
        mRemain = LAT;
      end
      mAt = 1'b1;
`ifdef KINEMATIC_RAMP_CONTROLLER_RAMP_EN
      for (int i = 0; i < 4; i++) if (mWheel[i] != mTarget[i]) mAt = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      check("m_w1", w1, mWheel[0]);
      check("m_w2", w2, mWheel[1]);
      check("m_w3", w3, mWheel[2]);
      check("m_w4", w4, mWheel[3]);
      check("m_busy", busy, int'(mRemain > 0));
      check("m_cmddone", cmdDone, int'(mDone));
      check("m_attarget", atTarget, int'(mAt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int x, input int y, input int z, input bit v);
    vx = N'(x);
    vy = N'(y);
    wz = N'(z);
    valid = v;
  endtask

  task automatic sendCmd(input int x, input int y, input int z);
    drive(x, y, z, 1'b1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Cycles from the negedge after the sampling edge until CMDDONE is seen; 0 if it never comes.
  task automatic waitDone(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (cmdDone === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic settle(input string name);
`ifdef KINEMATIC_RAMP_CONTROLLER_RAMP_EN
    int n;
    n = 0;
    while (atTarget !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(name, atTarget, 1);
`else
    @(negedge clk);
`endif
  endtask

  function automatic int randVal();
    logic signed [N-1:0] r;
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 4000)) - 2000;
      1: begin
        r = N'($urandom);
        return int'(r);
      end
      2: case ($urandom_range(0, 2))
        0: return MINV;
        1: return MAXV;
        default: return 0;
      endcase
      default: return int'($urandom_range(0, 600)) - 300;
    endcase
  endfunction

  initial begin
    int lat, cnt;
    quad_t t;
    logic signed [N-1:0] prevW;

    drive(0, 0, 0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkQuad("reset", 0, 0, 0, 0);
    check("reset_busy", busy, 0);
    check("reset_cmddone", cmdDone, 0);
    check("reset_attarget", atTarget, 1);
    rst = 1'b0;

    t = ikTargets(256, 0, 0);
    check("pin_fwd_t1", t[0], 1280);
    check("pin_fwd_t4", t[3], 1280);
    t = ikTargets(0, 256, 0);
    check("pin_side_t1", t[0], -1280);
    check("pin_side_t2", t[1], 1280);
    t = ikTargets(0, 0, 256);
    check("pin_rot_t1", t[0], -320);
    check("pin_rot_t2", t[1], 320);
    t = ikTargets(32767, 32767, 0);
    check("pin_sat_t1", t[0], 0);
    check("pin_sat_t2", t[1], 65535);
    @(negedge clk);

    // Forward motion: latency and per-tick rise
    sendCmd(256, 0, 0);
    waitDone(lat);
    check("t1_latency", lat, LAT);
`ifdef KINEMATIC_RAMP_CONTROLLER_RAMP_EN
    check("t1_commit_w1", w1, 0);
    cnt = 0;
    prevW = w1;
    for (int i = 0; i < 400 && atTarget !== 1'b1; i++) begin
      @(negedge clk);
      if (w1 !== prevW) cnt++;
      prevW = w1;
    end
    check("t1_ticks", cnt, 80);
`else
    checkQuad("t1_commit", 1280, 1280, 1280, 1280);
`endif
    settle("t1_settle");
    checkQuad("t1", 1280, 1280, 1280, 1280);

    // Sideways motion: negative targets
    sendCmd(0, 256, 0);
    waitDone(lat);
    check("t2_latency", lat, LAT);
    settle("t2_settle");
    checkQuad("t2", -1280, 1280, 1280, -1280);

    // Rotation
    sendCmd(0, 0, 256);
    waitDone(lat);
    check("t3_latency", lat, LAT);
    settle("t3_settle");
    checkQuad("t3", -320, 320, -320, 320);

    // Saturation, no wrap
    sendCmd(32767, 32767, 0);
    waitDone(lat);
    check("t4_latency", lat, LAT);
    settle("t4_settle");
    checkQuad("t4", 0, 65535, 65535, 0);

    // Commands while busy: last one pending wins
    drive(128, 0, 0, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    drive(256, 0, 0, 1'b1);
    @(negedge clk);
    drive(512, 0, 0, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (cmdDone === 1'b1) cnt++;
    end
    check("t5_commits", cnt, 2);
    settle("t5_settle");
    checkQuad("t5", 2560, 2560, 2560, 2560);

    // Reset mid-SCALE abandons the command
    sendCmd(128, 0, 0);
    waitDone(lat);
    settle("t6_pre_settle");
    check("t6_pre_w1", w1, 640);
    sendCmd(256, 0, 0);
    repeat (3) @(negedge clk);
    check("t6_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkQuad("t6_reset", 0, 0, 0, 0);
    check("t6_busy", busy, 0);
    check("t6_cmddone", cmdDone, 0);
    check("t6_attarget", atTarget, 1);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (cmdDone === 1'b1) cnt++;
    end
    check("t6_no_commit", cnt, 0);

    // Random commands, including back-to-back and occasional resets
    for (int n = 0; n < 250; n++) begin
      int gap;
      gap = $urandom_range(0, 9);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(randVal(), randVal(), randVal(), 1'b1);
      @(negedge clk);
      valid = 1'b0;
    end
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
